// File: rtl/cla_16_pipe_if.sv
// rtl/cla_16_pipe_if.sv - operand/result handshake bundle for the pipelined 16-bit CLA
interface cla_16_pipe_if;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] sum;
  logic        cout;
  logic        ovf;

  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );
endinterface

// File: rtl/cla_16_pipe.sv
// rtl/cla_16_pipe.sv - two-stage 16-bit carry-lookahead adder with valid/ready flow control
// Stage 1 registers bit and nibble propagate/generate; stage 2 resolves carries and registers the result.
module cla_16_pipe (
  input  logic         clk,
  input  logic         rst,
  cla_16_pipe_if.slave bus
);

  logic [15:0] p_in, g_in;
  logic [3:0]  pk_in, gk_in;

  logic        s1_valid;
  logic [15:0] s1_a, s1_b, s1_p, s1_g;
  logic        s1_cin;
  logic [3:0]  s1_pk, s1_gk;

  logic [4:0]  nc;
  logic [15:0] c;
  logic [15:0] sum_next;
  logic        ovf_next;

  logic        out_valid_r;
  logic [15:0] sum_r;
  logic        cout_r, ovf_r;

  logic        load2;
  logic        accept;

  assign p_in = bus.a ^ bus.b;
  assign g_in = bus.a & bus.b;

  for (genvar k = 0; k < 4; k++) begin : g_grp
    localparam int B = 4 * k;
    assign pk_in[k] = &p_in[B+3:B];
    assign gk_in[k] = g_in[B+3]
                    | (p_in[B+3] & g_in[B+2])
                    | (p_in[B+3] & p_in[B+2] & g_in[B+1])
                    | (p_in[B+3] & p_in[B+2] & p_in[B+1] & g_in[B]);
  end

  // Nibble carry-ins, each expanded directly from cin so no carry ripples between nibbles.
  assign nc[0] = s1_cin;
  assign nc[1] = s1_gk[0] | (s1_pk[0] & s1_cin);
  assign nc[2] = s1_gk[1] | (s1_pk[1] & s1_gk[0]) | (s1_pk[1] & s1_pk[0] & s1_cin);
  assign nc[3] = s1_gk[2] | (s1_pk[2] & s1_gk[1]) | (s1_pk[2] & s1_pk[1] & s1_gk[0])
               | (s1_pk[2] & s1_pk[1] & s1_pk[0] & s1_cin);
  assign nc[4] = s1_gk[3] | (s1_pk[3] & s1_gk[2]) | (s1_pk[3] & s1_pk[2] & s1_gk[1])
               | (s1_pk[3] & s1_pk[2] & s1_pk[1] & s1_gk[0])
               | (s1_pk[3] & s1_pk[2] & s1_pk[1] & s1_pk[0] & s1_cin);

  for (genvar k = 0; k < 4; k++) begin : g_bitc
    localparam int B = 4 * k;
    assign c[B]   = nc[k];
    assign c[B+1] = s1_g[B] | (s1_p[B] & nc[k]);
    assign c[B+2] = s1_g[B+1] | (s1_p[B+1] & s1_g[B]) | (s1_p[B+1] & s1_p[B] & nc[k]);
    assign c[B+3] = s1_g[B+2] | (s1_p[B+2] & s1_g[B+1]) | (s1_p[B+2] & s1_p[B+1] & s1_g[B])
                  | (s1_p[B+2] & s1_p[B+1] & s1_p[B] & nc[k]);
  end

  assign sum_next = s1_p ^ c;
  assign ovf_next = c[15] ^ nc[4];

  // Raw operands and top-of-nibble generates are held for observability only.
  logic unused_stage1_bits;
  assign unused_stage1_bits = ^{s1_a, s1_b, s1_g[15], s1_g[11], s1_g[7], s1_g[3]};

  assign load2        = s1_valid & (~out_valid_r | bus.out_ready);
  assign bus.in_ready = ~s1_valid | load2;
  assign accept       = bus.in_valid & bus.in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_cin   <= 1'b0;
      s1_p     <= '0;
      s1_g     <= '0;
      s1_pk    <= '0;
      s1_gk    <= '0;
    end else if (accept) begin
      s1_valid <= 1'b1;
      s1_a     <= bus.a;
      s1_b     <= bus.b;
      s1_cin   <= bus.cin;
      s1_p     <= p_in;
      s1_g     <= g_in;
      s1_pk    <= pk_in;
      s1_gk    <= gk_in;
    end else if (load2) begin
      s1_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_r <= 1'b0;
      sum_r       <= '0;
      cout_r      <= 1'b0;
      ovf_r       <= 1'b0;
    end else if (load2) begin
      out_valid_r <= 1'b1;
      sum_r       <= sum_next;
      cout_r      <= nc[4];
      ovf_r       <= ovf_next;
    end else if (bus.out_ready) begin
      out_valid_r <= 1'b0;
    end
  end

  assign bus.out_valid = out_valid_r;
  assign bus.sum       = sum_r;
  assign bus.cout      = cout_r;
  assign bus.ovf       = ovf_r;

endmodule
